// File: rtl/io_pkg.sv
// Shared types and constants for the CPU-side packet feeder.
// The state list mirrors the decoder's header/payload loading sequence.
package io_pkg;

  localparam int HEADER_WORDS = 2;
  localparam int BUS_WIDTH    = 32;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    LOAD,
    HDR0,
    HDR1,
    STREAM,
    DONE
  } state_t;

  function automatic logic is_loading(input state_t s);
    return (s == LOAD) || (s == HDR0) || (s == HDR1) || (s == STREAM);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with head-of-queue read data and an occupancy count.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // NOTE: storage has no reset; the pointers and count alone define validity.
  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/cpu_packet_feeder.sv
// Buffers CPU words and replays them to the run-length decoder with its
// header timing, then one payload word per Done_Processing_Current_Packet.
module cpu_packet_feeder
  import io_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] In_Data,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic                 Start,
  input  logic                 Done_Processing_Current_Packet,
  input  logic                 Done_Loading,
  output logic [BUS_WIDTH-1:0] CPU_Bus,
  output logic                 Loading_Enable,
  output logic                 Underrun,
  output logic                 Overrun,
  output logic                 Stream_Done,
  output logic [15:0]          Words_Sent
);

  state_t               r_state, w_next;
  logic [BUS_WIDTH-1:0] r_bus, w_head;
  logic [15:0]          r_words;
  logic                 r_pending, r_first, r_under, r_over;
  logic                 w_full, w_empty, w_push, w_pop;
  logic                 w_send, w_discard, w_hs;
  logic                 w_set_under, w_set_over, w_set_pend, w_clr_pend, w_clr_stats;
  logic [PTR_WIDTH:0]   w_count;

  assign w_push = In_Valid && !w_full;
  assign w_pop  = w_send || w_discard;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(BUS_WIDTH)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (In_Data),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_next      = r_state;
    w_send      = 1'b0;
    w_discard   = 1'b0;
    w_set_under = 1'b0;
    w_set_over  = 1'b0;
    w_set_pend  = 1'b0;
    w_clr_pend  = 1'b0;
    w_clr_stats = 1'b0;
    w_hs        = Done_Processing_Current_Packet && !r_first;
    case (r_state)
      IDLE:  if (Start) w_next = PRIME;
      PRIME: begin
        // Both header words plus the first payload word must be on hand.
        if (w_count >= (PTR_WIDTH+1)'(HEADER_WORDS + 1)) begin
          w_send = 1'b1;
          w_next = LOAD;
        end
      end
      LOAD:  w_next = HDR0;
      HDR0:  begin w_send = 1'b1; w_next = HDR1;   end
      HDR1:  begin w_send = 1'b1; w_next = STREAM; end
      STREAM: begin
        if (Done_Loading) begin
          w_clr_pend = 1'b1;
          w_next     = DONE;
        end else begin
          if (w_hs && r_pending) w_set_over = 1'b1;
          if ((w_hs || r_pending) && !w_empty) begin
            w_send     = 1'b1;
            w_clr_pend = 1'b1;
          end else if (w_hs && w_empty) begin
            w_set_under = 1'b1;
            w_set_pend  = 1'b1;
          end
        end
      end
      DONE: begin
        if (Start) begin
          w_clr_stats = 1'b1;
          w_next      = PRIME;
        end else if (!w_empty) begin
          w_discard = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_bus     <= '0;
      r_words   <= '0;
      r_pending <= 1'b0;
      r_first   <= 1'b0;
      r_under   <= 1'b0;
      r_over    <= 1'b0;
    end else begin
      r_state <= w_next;
      // The decoder's handshake resets high, so ignore it on the first STREAM cycle.
      r_first <= (r_state == HDR1);
      if (w_send) begin
        r_bus <= w_head;
        if (r_words != 16'hFFFF) r_words <= r_words + 16'd1;
      end else if (w_clr_stats) begin
        r_words <= '0;
      end
      if (w_clr_pend)      r_pending <= 1'b0;
      else if (w_set_pend) r_pending <= 1'b1;
      if (w_clr_stats)       r_under <= 1'b0;
      else if (w_set_under)  r_under <= 1'b1;
      if (w_clr_stats)       r_over <= 1'b0;
      else if (w_set_over)   r_over <= 1'b1;
    end
  end

  assign In_Ready       = !w_full;
  assign CPU_Bus        = r_bus;
  assign Loading_Enable = is_loading(r_state);
  assign Stream_Done    = (r_state == DONE);
  assign Underrun       = r_under;
  assign Overrun        = r_over;
  assign Words_Sent     = r_words;

endmodule

// File: tb/tb_cpu_packet_feeder.sv
// Directed header/handshake/full/termination/reset scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
module tb_cpu_packet_feeder;

  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] In_Data = '0;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic        Start = 1'b0;
  logic        Done_Processing_Current_Packet = 1'b0;
  logic        Done_Loading = 1'b0;
  logic [31:0] CPU_Bus;
  logic        Loading_Enable;
  logic        Underrun;
  logic        Overrun;
  logic        Stream_Done;
  logic [15:0] Words_Sent;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  cpu_packet_feeder #(.DEPTH(DEPTH), .PTR_WIDTH(4)) dut (
    .CLK                            (CLK),
    .RST                            (RST),
    .In_Data                        (In_Data),
    .In_Valid                       (In_Valid),
    .In_Ready                       (In_Ready),
    .Start                          (Start),
    .Done_Processing_Current_Packet (Done_Processing_Current_Packet),
    .Done_Loading                   (Done_Loading),
    .CPU_Bus                        (CPU_Bus),
    .Loading_Enable                 (Loading_Enable),
    .Underrun                       (Underrun),
    .Overrun                        (Overrun),
    .Stream_Done                    (Stream_Done),
    .Words_Sent                     (Words_Sent)
  );

  // Reference model: buffered words in a queue, a phase number, and the
  // cycles elapsed since payload streaming began.
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_HDR = 2, PH_STREAM = 3, PH_DONE = 4;
  int          q[$];
  int          ph = PH_IDLE;
  int          hdr_step = 0;
  int          stream_cycles = 0;
  bit          pend = 0;
  logic [31:0] e_bus = '0;
  bit          e_under = 0, e_over = 0;
  int          e_ws = 0;

  task automatic model_send();
    e_bus = q.pop_front();
    if (e_ws < 65535) e_ws++;
  endtask

  task automatic model_edge(input bit v, input logic [31:0] d, input bit st,
                            input bit hs, input bit dl, input bit rs);
    bit accept;
    accept = v && (q.size() < DEPTH);
    if (rs) begin
      q.delete();
      ph = PH_IDLE; hdr_step = 0; stream_cycles = 0; pend = 0;
      e_bus = '0; e_under = 0; e_over = 0; e_ws = 0;
      return;
    end
    case (ph)
      PH_IDLE: if (st) ph = PH_WAIT;
      PH_WAIT: if (q.size() >= 3) begin model_send(); ph = PH_HDR; hdr_step = 0; end
      PH_HDR: begin
        // Header sequence: one enable cycle, then word1 and word2 popped on successive edges.
        hdr_step++;
        if (hdr_step >= 2) model_send();
        if (hdr_step == 3) begin ph = PH_STREAM; stream_cycles = 0; end
      end
      PH_STREAM: begin
        if (dl) begin
          ph = PH_DONE; pend = 0;
        end else begin
          bit req;
          req = hs && (stream_cycles > 0);
          if (req && pend) e_over = 1;
          if ((req || pend) && q.size() > 0) begin
            model_send(); pend = 0;
          end else if (req) begin
            e_under = 1; pend = 1;
          end
        end
        stream_cycles++;
      end
      PH_DONE: begin
        if (st) begin
          ph = PH_WAIT; e_under = 0; e_over = 0; e_ws = 0;
        end else if (q.size() > 0) begin
          void'(q.pop_front());
        end
      end
      default: ph = PH_IDLE;
    endcase
    if (accept) q.push_back(d);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("cpu_bus",     CPU_Bus,        e_bus);
    check("load_en",     {31'b0, Loading_Enable}, {31'b0, (ph == PH_HDR) || (ph == PH_STREAM)});
    check("in_ready",    {31'b0, In_Ready},       {31'b0, q.size() < DEPTH});
    check("underrun",    {31'b0, Underrun},       {31'b0, e_under});
    check("overrun",     {31'b0, Overrun},        {31'b0, e_over});
    check("stream_done", {31'b0, Stream_Done},    {31'b0, ph == PH_DONE});
    check("words_sent",  {16'b0, Words_Sent},     32'(e_ws));
  endtask

  task automatic tick(input bit v, input logic [31:0] d, input bit st,
                      input bit hs, input bit dl, input bit rs);
    In_Valid = v; In_Data = d; Start = st;
    Done_Processing_Current_Packet = hs; Done_Loading = dl; RST = rs;
    @(posedge CLK);
    model_edge(v, d, st, hs, dl, rs);
    #1;
    compare_all();
  endtask

  initial begin
    tick(0, 0, 0, 0, 0, 1);
    check("rst_bus", CPU_Bus, 32'h0);
    check("rst_ready", {31'b0, In_Ready}, 32'h1);

    // Header timing
    tick(1, 32'h8, 0, 0, 0, 0);
    tick(1, 32'h3, 0, 0, 0, 0);
    tick(1, 32'hA1, 0, 0, 0, 0);
    tick(1, 32'hA2, 0, 0, 0, 0);
    tick(1, 32'hA3, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("load_bus", CPU_Bus, 32'h8);
    check("load_le", {31'b0, Loading_Enable}, 32'h1);
    tick(0, 0, 0, 0, 0, 0);
    check("hdr0_bus", CPU_Bus, 32'h8);
    tick(0, 0, 0, 0, 0, 0);
    check("hdr1_bus", CPU_Bus, 32'h3);
    tick(0, 0, 0, 0, 0, 0);
    check("first_payload", CPU_Bus, 32'hA1);
    check("ws_after_hdr", {16'b0, Words_Sent}, 32'd3);

    // Handshake: first STREAM cycle masked, then single and back-to-back requests
    tick(0, 0, 0, 1, 0, 0);
    check("masked_hs", CPU_Bus, 32'hA1);
    tick(0, 0, 0, 1, 0, 0);
    check("hs_a2", CPU_Bus, 32'hA2);
    tick(0, 0, 0, 1, 0, 0);
    check("hs_a3", CPU_Bus, 32'hA3);
    tick(0, 0, 0, 1, 0, 0);
    check("underrun_set", {31'b0, Underrun}, 32'h1);
    check("underrun_hold", CPU_Bus, 32'hA3);
    tick(1, 32'hA4, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("pending_fill", CPU_Bus, 32'hA4);
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    check("overrun_set", {31'b0, Overrun}, 32'h1);

    // Full FIFO, simultaneous push/pop at 15 words
    tick(1, 32'hB0, 0, 0, 0, 0);
    tick(1, 32'hB1, 0, 0, 0, 0);
    for (int i = 2; i < 16; i++) tick(1, 32'hB0 + 32'(i), 0, 0, 0, 0);
    tick(1, 32'hBF, 0, 1, 0, 0);
    check("push_pop_15", {31'b0, In_Ready}, 32'h1);
    tick(1, 32'hC0, 0, 0, 0, 0);
    check("full_ready", {31'b0, In_Ready}, 32'h0);
    tick(1, 32'hDEAD, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) tick(0, 0, 0, 1, 0, 0);

    // Termination with simultaneous handshake, then drain of 4 residual words
    tick(0, 0, 0, 1, 1, 0);
    check("done_sd", {31'b0, Stream_Done}, 32'h1);
    check("done_le", {31'b0, Loading_Enable}, 32'h0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    check("restart_under", {31'b0, Underrun}, 32'h0);
    check("restart_ws", {16'b0, Words_Sent}, 32'h0);
    tick(1, 32'h11, 0, 0, 0, 0);
    tick(1, 32'h22, 0, 0, 0, 0);
    tick(1, 32'h33, 0, 0, 0, 0);
    tick(1, 32'h44, 0, 0, 0, 0);
    check("drained", CPU_Bus, 32'h11);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);

    // Reset mid-STREAM with a word still buffered
    tick(0, 0, 0, 0, 0, 1);
    check("rst_stream_bus", CPU_Bus, 32'h0);
    check("rst_stream_le", {31'b0, Loading_Enable}, 32'h0);
    tick(0, 0, 1, 0, 0, 0);
    tick(1, 32'h55, 0, 0, 0, 0);
    tick(1, 32'h66, 0, 0, 0, 0);
    tick(1, 32'h77, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("rst_fifo_empty", CPU_Bus, 32'h55);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(1, 0) == 1, $urandom(), $urandom_range(19, 0) == 0,
           $urandom_range(2, 0) == 0, $urandom_range(59, 0) == 0,
           $urandom_range(399, 0) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
